// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_pkg
//  Purpose  : Shared widths, default reset PC and the prefetch-buffer entry
//             type used by the instruction fetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int LEVEL_W = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch: the instruction address and the word read there.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Small prefetch buffer with synchronous flush, push, pop and an
//             occupancy count. The head is taken from storage registers only,
//             so there is no combinational path from the write data.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_flush,
    input  logic               i_push,
    input  fetch_entry_t       i_push_entry,
    input  logic               i_pop,
    output fetch_entry_t       o_head,
    output logic [LEVEL_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] count_q, count_d;

    // Next-state: flush wins; otherwise push and pop act independently.
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + LEVEL_W'(i_push) - LEVEL_W'(i_pop);
        end
    end

    // Storage, pointers and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // An empty buffer presents zeros rather than a stale entry.
    assign o_head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Instruction fetch unit. Drives the PC to instruction memory,
//             captures {pc, inst} into a prefetch buffer and hands entries to
//             decode with a valid/ready handshake. Handles halt and redirect.
//  Options  : FETCH_ALIGN_CHK_EN - when defined, a redirect to a non word
//             aligned target raises a sticky AlignErr that stops fetching
//             until reset. When undefined the low target bits are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  ImAddr,
    input  logic [INST_W-1:0]  ImInst,
    input  logic               Halt,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPc,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [INST_W-1:0]  OutInst,
    output logic [ADDR_W-1:0]  OutPc,
    output logic [LEVEL_W-1:0] Level,
    output logic               AlignErr
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic              w_stall;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    // Redirect targets are always forced onto a word boundary.
    assign w_redirect_pc = {RedirectPc[ADDR_W-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
    logic align_err_q, align_err_d;

    // Sticky misaligned-redirect flag; only reset clears it.
    always_comb begin
        align_err_d = align_err_q;
        if (Redirect && (RedirectPc[1:0] != 2'b00)) begin
            align_err_d = 1'b1;
        end
    end

    // Alignment error register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign w_stall  = align_err_q;
    assign AlignErr = align_err_q;
`else
    logic w_unused_redirect_lsb;
    assign w_unused_redirect_lsb = ^RedirectPc[1:0];
    assign w_stall  = 1'b0;
    assign AlignErr = 1'b0;
`endif

    // Handshake: redirect discards any transfer in its cycle. A full buffer
    // may still accept a fetch when the head leaves in the same cycle.
    assign OutValid = (Level != '0);
    assign w_pop    = OutValid && OutReady && !Redirect;
    assign w_push   = !Redirect && !Halt && !w_stall &&
                      ((Level < LEVEL_W'(FIFO_DEPTH)) || w_pop);

    assign w_push_entry.pc   = pc_q;
    assign w_push_entry.inst = ImInst;

    // PC next-state: redirect, advance on fetch, otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (Redirect) begin
            pc_d = w_redirect_pc;
        end else if (w_push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ImAddr = pc_q;

    fetch_fifo #(
        .DEPTH        (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk          (Clk),
        .rst          (Reset),
        .i_flush      (Redirect),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (Level)
    );

    assign OutPc   = w_head.pc;
    assign OutInst = w_head.inst;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch
//  Purpose  : Self-checking bench for inst_fetch. A queue-based reference
//             model of the fetch unit is stepped each cycle; a second
//             instance with RESET_PC near the top of memory checks PC wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] RESET2  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        Reset, Halt, Redirect, OutReady;
    logic [31:0] RedirectPc;
    logic [31:0] ImAddr, ImInst, OutInst, OutPc;
    logic        OutValid, AlignErr;
    logic [3:0]  Level;

    logic [31:0] ImAddr2, ImInst2, OutInst2, OutPc2;
    logic        OutValid2, AlignErr2;
    logic [3:0]  Level2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instruction ROM: word k holds 32'h1000_0000 + k.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {27'd0, a[6:2]};
    endfunction

    assign ImInst  = rom_word(ImAddr);
    assign ImInst2 = rom_word(ImAddr2);

    inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut (
        .Clk(clk), .Reset(Reset), .ImAddr(ImAddr), .ImInst(ImInst),
        .Halt(Halt), .Redirect(Redirect), .RedirectPc(RedirectPc),
        .OutValid(OutValid), .OutReady(OutReady), .OutInst(OutInst),
        .OutPc(OutPc), .Level(Level), .AlignErr(AlignErr)
    );

    inst_fetch #(.RESET_PC(RESET2), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
        .Clk(clk), .Reset(Reset), .ImAddr(ImAddr2), .ImInst(ImInst2),
        .Halt(1'b0), .Redirect(1'b0), .RedirectPc(32'h0),
        .OutValid(OutValid2), .OutReady(1'b1), .OutInst(OutInst2),
        .OutPc(OutPc2), .Level(Level2), .AlignErr(AlignErr2)
    );

    // Reference model state.
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    bit          m_ae    = 1'b0;
    bit          m_init  = 1'b0;
    bit          m_clean = 1'b0;
    int          n2      = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Compare all visible outputs against the model before the next edge.
    task automatic compare();
        logic [31:0] e2;
        if (!m_init) return;
        check("ImAddr",   ImAddr, m_pc);
        check("Level",    {28'd0, Level}, 32'(m_q.size()));
        check("OutValid", 32'(OutValid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("OutPc",   OutPc,   m_q[0][63:32]);
            check("OutInst", OutInst, m_q[0][31:0]);
        end else if (m_clean) begin
            check("OutPc_rst",   OutPc,   32'h0);
            check("OutInst_rst", OutInst, 32'h0);
        end
        check("AlignErr", 32'(AlignErr), 32'(m_ae));
        if (n2 == 0) begin
            check("wrap_OutValid", 32'(OutValid2), 32'h0);
            check("wrap_OutPc",    OutPc2, 32'h0);
            check("wrap_ImAddr",   ImAddr2, RESET2);
        end else begin
            e2 = RESET2 + 32'(n2 - 1) * 32'd4;
            check("wrap_OutValid", 32'(OutValid2), 32'h1);
            check("wrap_OutPc",    OutPc2, e2);
            check("wrap_OutInst",  OutInst2, rom_word(e2));
            check("wrap_Level",    {28'd0, Level2}, 32'h1);
        end
        check("wrap_AlignErr", 32'(AlignErr2), 32'h0);
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_update();
        bit pop, push;
        if (Reset) begin
            m_q.delete();
            m_pc    = 32'h0;
            m_ae    = 1'b0;
            m_init  = 1'b1;
            m_clean = 1'b1;
            n2      = 0;
        end else begin
            n2++;
            if (Redirect) begin
                m_q.delete();
                m_pc = RedirectPc & ~32'h3;
`ifdef FETCH_ALIGN_CHK_EN
                if (RedirectPc[1:0] != 2'b00) m_ae = 1'b1;
`endif
            end else begin
                pop  = (m_q.size() != 0) && OutReady;
                push = !Halt && !m_ae && ((m_q.size() < DEPTH) || pop);
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    m_q.push_back({m_pc, rom_word(m_pc)});
                    m_pc    = m_pc + 32'd4;
                    m_clean = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        #3;
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rst, input bit hlt, input bit rdr,
                         input logic [31:0] rpc, input bit rdy, input int n);
        Reset = rst; Halt = hlt; Redirect = rdr; RedirectPc = rpc; OutReady = rdy;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [31:0] rp;
        Reset = 1'b1; Halt = 1'b0; Redirect = 1'b0; RedirectPc = 32'h0; OutReady = 1'b0;
        #1;
        // Reset with redirect and halt asserted: reset must dominate.
        drive(1, 1, 1, 32'h0000_0060, 1, 2);
        // Streaming, one instruction per cycle.
        drive(0, 0, 0, 32'h0, 1, 8);
        // Back-pressure: buffer fills, PC stalls, then drains in order.
        drive(0, 0, 0, 32'h0, 0, 6);
        drive(0, 0, 0, 32'h0, 1, 4);
        // Fill, then redirect to 0x40 with a full buffer.
        drive(0, 0, 0, 32'h0, 0, 3);
        drive(0, 0, 1, 32'h0000_0040, 1, 1);
        drive(0, 0, 0, 32'h0, 1, 4);
        // Halt while draining, then resume.
        drive(0, 1, 0, 32'h0, 1, 3);
        drive(0, 0, 0, 32'h0, 1, 4);
        // Misaligned redirect.
        drive(0, 0, 1, 32'h0000_0042, 1, 1);
        drive(0, 0, 0, 32'h0, 1, 5);
        drive(1, 0, 0, 32'h0, 1, 1);
        drive(0, 0, 0, 32'h0, 1, 3);
        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rp = $urandom_range(0, 127);
            if ($urandom_range(0, 9) != 0) rp[1:0] = 2'b00;
            Reset      = ($urandom_range(0, 99) == 0);
            Redirect   = ($urandom_range(0, 19) == 0);
            Halt       = ($urandom_range(0, 4) == 0);
            OutReady   = ($urandom_range(0, 2) != 0);
            RedirectPc = rp;
            step();
        end
        Reset = 1'b0; Halt = 1'b0; Redirect = 1'b0; OutReady = 1'b1;
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter: FIFO_DEPTH, 2, prefetch buffer entries (power of two, 2..8).
REQ-003 Clk  input  1  sole clock, rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ImAddr  output  32  byte address to instruction memory (word index = ImAddr[6:2]).
REQ-006 ImInst  input  32  instruction word returned combinationally for ImAddr in the same cycle.
REQ-007 Halt  input  1  suspend fetching; buffer keeps draining.
REQ-008 Redirect  input  1  branch/jump taken; flush and restart at RedirectPc.
REQ-009 RedirectPc  input  32  redirect target byte address.
REQ-010 OutValid  output  1  head entry valid to decode.
REQ-011 OutReady  input  1  decode accepts head entry.
REQ-012 OutInst  output  32  head instruction word.
REQ-013 OutPc  output  32  head instruction address.
REQ-014 Level  output  4  current buffer occupancy.
REQ-015 AlignErr  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-016 ImAddr shall equal the internal PC register combinationally at all times.
REQ-017 Push condition: !Redirect && !Halt && !AlignErr && (Level<FIFO_DEPTH || pop); push writes {PC, ImInst} and PC <= PC+4.
REQ-018 Pop shall occur when OutValid && OutReady && !Redirect.
REQ-019 OutValid shall be 1 iff Level!=0; OutInst/OutPc shall show the oldest entry, registered (no combinational path from ImInst).
REQ-020 Full with simultaneous pop shall push and pop in the same cycle; Level unchanged.
REQ-021 Redirect sampled high at edge E: buffer emptied, PC <= RedirectPc, no push, any handshake that cycle discarded; fetch of RedirectPc at E+1; OutValid=1 with OutPc=RedirectPc after E+1.
REQ-022 Redirect shall take priority over Halt, push and pop.
REQ-023 Halt high: PC frozen, no push; entries still pop; deassert resumes at frozen PC next edge.
REQ-024 PC shall wrap from 32'hFFFFFFFC to 32'h00000000 with no flag.
REQ-025 Entries shall leave in push order; no entry duplicated or dropped except by Redirect flush.

Reset
REQ-026 On Reset at an edge: PC=RESET_PC, Level=0, OutValid=0, OutInst=0, OutPc=0, AlignErr=0.
REQ-027 Reset shall override Redirect and Halt; first push occurs at the first edge with Reset low, OutValid=1 thereafter.
REQ-028 Reset asserted mid-stream shall discard all buffered entries.

Configuration
REQ-029 Macro FETCH_ALIGN_CHK_EN defined: Redirect with RedirectPc[1:0]!=0 sets AlignErr (sticky until Reset), flushes buffer, halts all pushes; PC loaded with RedirectPc & ~3.
REQ-030 Macro undefined: RedirectPc[1:0] forced to 00, AlignErr tied 0, no related logic.

Structure
REQ-031 Package fetch_pkg shall hold INST_W=32, ADDR_W=32, default RESET_PC, and the buffer entry type {pc, inst}.
REQ-032 Buffer shall be sub-module fetch_fifo (synchronous flush, push, pop, count); PC and control in inst_fetch.

Verification
REQ-033 Reset release, OutReady=1, ROM word k = 32'h1000_0000+k -> OutPc 0,4,8,... one per cycle, OutInst matches, first valid one edge after Reset low.
REQ-034 OutReady=0 for 5 cycles -> Level saturates at 2, ImAddr stops at 8, PC entries 0,4 held; OutReady=1 -> 0,4,8 in order, no gap.
REQ-035 Redirect to 32'h40 with Level=2 -> Level=0 next edge, OutValid=0 one cycle, then OutPc=32'h40, 32'h44.
REQ-036 Halt=1 for 3 cycles with OutReady=1 -> buffer drains, OutValid=0, ImAddr frozen; Halt=0 -> continues from frozen PC.
REQ-037 RESET_PC=32'hFFFFFFF8 -> OutPc sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-038 With FETCH_ALIGN_CHK_EN, Redirect to 32'h42 -> AlignErr=1, OutValid=0 until Reset; without macro -> OutPc=32'h40, AlignErr=0.
